// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: ISA field codes,
// controller state encoding and ALU operation codes.
package mips_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Controller states; the encoding is visible on state_dbg
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_NOR = 4'd4,
      ALU_SLT = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7,
      ALU_LUI = 4'd8
   } alu_op_t;

   // R-type funct to ALU operation (only reached for supported functs)
   function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_NOR:  return ALU_NOR;
         FN_SLT:  return ALU_SLT;
         FN_SLL:  return ALU_SLL;
         FN_SRL:  return ALU_SRL;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ALU.sv
// Combinational ALU shared by address, branch-target and execute steps.
module ALU
   import mips_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [4:0]   i_shamt,
   input  alu_op_t      i_op,
   output logic [W-1:0] o_y
);

   // Operation select; add/sub wrap naturally, no overflow trap
   always_comb begin
      o_y = '0;
      case (i_op)
         ALU_ADD: o_y = i_a + i_b;
         ALU_SUB: o_y = i_a - i_b;
         ALU_AND: o_y = i_a & i_b;
         ALU_OR:  o_y = i_a | i_b;
         ALU_NOR: o_y = ~(i_a | i_b);
         ALU_SLT: o_y = W'($signed(i_a) < $signed(i_b));
         ALU_SLL: o_y = i_b << i_shamt;
         ALU_SRL: o_y = i_b >> i_shamt;
         ALU_LUI: o_y = i_b << 16;
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/RegisterFile.sv
// 32-entry register file, two async read ports, one write port.
// $0 is hard-wired to zero: writes to it are dropped.
module RegisterFile #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_we,
   input  logic [4:0]   i_waddr,
   input  logic [W-1:0] i_wdata,
   input  logic [4:0]   i_raddr1,
   input  logic [4:0]   i_raddr2,
   output logic [W-1:0] o_rdata1,
   output logic [W-1:0] o_rdata2
);

   logic [31:0][W-1:0] r_regs;

   // Register storage, cleared on reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_regs <= '0;
      else if (i_we && (i_waddr != 5'd0))
         r_regs[i_waddr] <= i_wdata;
   end

   assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle controller: sequences fetch/decode/execute and owns the
// memory handshake (request strobes and access-complete indication).
module mips_mc_control
   import mips_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_mem_ready,
   input  logic       i_io_hit,
   output logic [3:0] o_state,
   output logic       o_mem_re,
   output logic       o_mem_we,
   output logic       o_access_done
);

   state_t r_state, w_next;

   assign o_state = r_state;

   // State register; reset aborts any access in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_FETCH;
      else          r_state <= w_next;
   end

   // Next-state and handshake strobes. Strobes are gated by reset so a
   // pending request drops as soon as reset asserts. mem_ready is only
   // looked at in FETCH/MEM_RD/MEM_WR.
   always_comb begin
      w_next        = r_state;
      o_mem_re      = 1'b0;
      o_mem_we      = 1'b0;
      o_access_done = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_mem_re      = i_rst_n;
            o_access_done = i_mem_ready;
            if (i_mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            case (i_opcode)
               OP_RTYPE: begin
                  case (i_funct)
                     FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR,
                     FN_SLT, FN_SLL, FN_SRL: w_next = S_EXEC_R;
                     FN_JR:                  w_next = S_JUMP;
                     default:                w_next = S_FETCH;
                  endcase
               end
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXEC_I;
               OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
               OP_J, OP_JAL:                     w_next = S_JUMP;
               default:                          w_next = S_FETCH;
            endcase
         end
         S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
         S_MEM_ADDR:         w_next = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            // IO port reads complete immediately, without a bus request
            o_mem_re      = i_rst_n & ~i_io_hit;
            o_access_done = i_mem_ready | i_io_hit;
            if (o_access_done) w_next = S_MEM_WB;
         end
         S_MEM_WR: begin
            o_mem_we      = i_rst_n & ~i_io_hit;
            o_access_done = i_mem_ready | i_io_hit;
            if (o_access_done) w_next = S_FETCH;
         end
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
         default: w_next = S_FETCH;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_processor.sv
// Multicycle MIPS core: datapath registers (PC/IR/A/B/ALUOut/MDR),
// register file, ALU and controller, with one memory-mapped IO port.
module mips_multicycle_processor
   import mips_pkg::*;
#(
   parameter int          MEMORY_DEPTH = 512,
   parameter int          DATA_WIDTH   = 32,
   parameter logic [31:0] PC_RESET     = 32'h0040_0000,
   parameter logic [31:0] IO_ADDR      = 32'h1001_0024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ready,
   input  logic [7:0]            PortIn,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] PortOut,
   output logic [DATA_WIDTH-1:0] ALUResultOut,
   output logic [3:0]            state_dbg
);

   localparam int W = DATA_WIDTH;

   // Addresses and the PC are 32 bits; a narrower datapath cannot form them
   if (DATA_WIDTH < 32 || MEMORY_DEPTH < 1) begin : g_param_check
      $error("mips_multicycle_processor: DATA_WIDTH must be >= 32 and MEMORY_DEPTH >= 1");
   end

   logic [31:0]  r_pc, r_ir;
   logic [W-1:0] r_a, r_b, r_aluout, r_mdr, r_portout;

   logic [3:0]   w_state_raw;
   state_t       w_state;
   logic         w_access_done, w_io_hit, w_taken;
   logic [W-1:0] w_rf1, w_rf2, w_alu_a, w_alu_b, w_alu_y, w_rf_wdata;
   alu_op_t      w_alu_op;
   logic         w_rf_we;
   logic [4:0]   w_rf_waddr;

   // Instruction fields
   logic [5:0]   w_op, w_funct;
   logic [4:0]   w_rs, w_rt, w_rd, w_shamt;
   logic [15:0]  w_imm;
   logic [W-1:0] w_sext, w_zext, w_pc_ext;

   assign w_op     = r_ir[31:26];
   assign w_rs     = r_ir[25:21];
   assign w_rt     = r_ir[20:16];
   assign w_rd     = r_ir[15:11];
   assign w_shamt  = r_ir[10:6];
   assign w_funct  = r_ir[5:0];
   assign w_imm    = r_ir[15:0];
   assign w_sext   = {{(W-16){w_imm[15]}}, w_imm};
   assign w_zext   = {{(W-16){1'b0}}, w_imm};
   assign w_pc_ext = W'(r_pc);

   assign w_state  = state_t'(w_state_raw);
   assign w_io_hit = (r_aluout[31:0] == IO_ADDR);
   assign w_taken  = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

   assign mem_addr     = (w_state == S_FETCH) ? r_pc : r_aluout[31:0];
   assign mem_wdata    = r_b;
   assign PortOut      = r_portout;
   assign ALUResultOut = r_aluout;
   assign state_dbg    = w_state_raw;

   mips_mc_control u_ctrl (
      .i_clk        (clk),
      .i_rst_n      (reset),
      .i_opcode     (w_op),
      .i_funct      (w_funct),
      .i_mem_ready  (mem_ready),
      .i_io_hit     (w_io_hit),
      .o_state      (w_state_raw),
      .o_mem_re     (mem_re),
      .o_mem_we     (mem_we),
      .o_access_done(w_access_done)
   );

   RegisterFile #(.W(W)) u_rf (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_we    (w_rf_we),
      .i_waddr (w_rf_waddr),
      .i_wdata (w_rf_wdata),
      .i_raddr1(w_rs),
      .i_raddr2(w_rt),
      .o_rdata1(w_rf1),
      .o_rdata2(w_rf2)
   );

   ALU #(.W(W)) u_alu (
      .i_a    (w_alu_a),
      .i_b    (w_alu_b),
      .i_shamt(w_shamt),
      .i_op   (w_alu_op),
      .o_y    (w_alu_y)
   );

   // ALU operand/operation select: branch target in DECODE, execute
   // results in EXEC_R/EXEC_I, effective address in MEM_ADDR
   always_comb begin
      w_alu_a  = r_a;
      w_alu_b  = r_b;
      w_alu_op = ALU_ADD;
      case (w_state)
         S_DECODE: begin
            w_alu_a = w_pc_ext;
            w_alu_b = w_sext << 2;
         end
         S_EXEC_R: w_alu_op = funct_to_alu(w_funct);
         S_EXEC_I: begin
            case (w_op)
               OP_ANDI: begin w_alu_b = w_zext; w_alu_op = ALU_AND; end
               OP_ORI:  begin w_alu_b = w_zext; w_alu_op = ALU_OR;  end
               OP_LUI:  begin w_alu_b = w_zext; w_alu_op = ALU_LUI; end
               default: w_alu_b = w_sext;
            endcase
         end
         S_MEM_ADDR: w_alu_b = w_sext;
         default: ;
      endcase
   end

   // Register-file write port: ALU result, loaded word, or jal link
   always_comb begin
      w_rf_we    = 1'b0;
      w_rf_waddr = 5'd0;
      w_rf_wdata = '0;
      case (w_state)
         S_ALU_WB: begin
            w_rf_we    = 1'b1;
            w_rf_waddr = (w_op == OP_RTYPE) ? w_rd : w_rt;
            w_rf_wdata = r_aluout;
         end
         S_MEM_WB: begin
            w_rf_we    = 1'b1;
            w_rf_waddr = w_rt;
            w_rf_wdata = r_mdr;
         end
         S_JUMP: begin
            // PC already points past the jal at this point
            w_rf_we    = (w_op == OP_JAL);
            w_rf_waddr = 5'd31;
            w_rf_wdata = w_pc_ext;
         end
         default: ;
      endcase
   end

   // Datapath registers, updated according to the current state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc      <= PC_RESET;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_aluout  <= '0;
         r_mdr     <= '0;
         r_portout <= '0;
      end else begin
         case (w_state)
            S_FETCH: begin
               if (w_access_done) begin
                  r_ir <= mem_rdata;
                  r_pc <= r_pc + 32'd4;
               end
            end
            S_DECODE: begin
               r_a      <= w_rf1;
               r_b      <= w_rf2;
               r_aluout <= w_alu_y;
            end
            S_EXEC_R, S_EXEC_I, S_MEM_ADDR: r_aluout <= w_alu_y;
            S_MEM_RD: begin
               if (w_access_done)
                  r_mdr <= w_io_hit ? W'(PortIn) : W'(mem_rdata);
            end
            S_MEM_WR: begin
               if (w_access_done && w_io_hit) r_portout <= r_b;
            end
            S_BRANCH: begin
               if (w_taken) r_pc <= r_aluout[31:0];
            end
            S_JUMP: begin
               if (w_op == OP_RTYPE) r_pc <= r_a[31:0];
               else                  r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_processor.sv
// Directed bench for the multicycle MIPS core with a simple unified
// memory model (separate instruction/data wait-state settings).
module tb_mips_multicycle_processor;

   localparam logic [31:0] PCR = 32'h0040_0000;
   localparam logic [31:0] IOA = 32'h1001_0024;
   localparam logic [31:0] NOP = 32'hFC00_0000;  // unsupported opcode

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [7:0]  PortIn = 8'h00;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re, mem_we;
   logic [31:0] PortOut, ALUResultOut;
   logic [3:0]  state_dbg;

   logic [31:0] imem [128];
   logic [31:0] dmem [64];
   int iwait = 0, dwait = 0, wcnt = 0;
   int we_cyc = 0, both_cyc = 0, io_cyc = 0;
   int checks = 0, errors = 0;
   logic is_i;

   always #5 clk = ~clk;

   mips_multicycle_processor dut (
      .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .PortIn(PortIn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_we(mem_we), .PortOut(PortOut),
      .ALUResultOut(ALUResultOut), .state_dbg(state_dbg)
   );

   assign is_i      = (mem_addr[31:20] == 12'h004);
   assign mem_rdata = is_i ? imem[mem_addr[8:2]] : dmem[mem_addr[7:2]];
   assign mem_ready = (mem_re | mem_we) && (wcnt == (is_i ? iwait : dwait));

   // memory responder and bus activity counters
   always @(posedge clk) begin
      if ((mem_re | mem_we) && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_we && mem_ready) dmem[mem_addr[7:2]] <= mem_wdata;
      if (mem_we) we_cyc <= we_cyc + 1;
      if (mem_re && mem_we) both_cyc <= both_cyc + 1;
      if ((mem_re | mem_we) && mem_addr == IOA) io_cyc <= io_cyc + 1;
   end

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction
   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] enc_j(int op, logic [31:0] a);
      return {6'(op), a[27:2]};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_imem();
      for (int i = 0; i < 128; i++) imem[i] = NOP;
   endtask

   task automatic start();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clr_imem();
      reset = 1'b0;
      tick(2);
      checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
      checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_strobes: got re=%b we=%b expected 0 0", mem_re, mem_we); end
      checks++; if (PortOut !== 32'h0 || ALUResultOut !== 32'h0) begin errors++; $display("FAIL rst_outs: got port=%h alu=%h expected 0 0", PortOut, ALUResultOut); end
      reset = 1'b1;
      #1;
      checks++; if (mem_re !== 1'b1 || mem_addr !== PCR) begin errors++; $display("FAIL rst_first_fetch: got re=%b addr=%h expected 1 %h", mem_re, mem_addr, PCR); end
      tick(1);
      checks++; if (state_dbg !== 4'd1) begin errors++; $display("FAIL rst_decode: got %0d expected 1", state_dbg); end
      tick(1);
      checks++; if (state_dbg !== 4'd0 || mem_addr !== PCR + 4) begin errors++; $display("FAIL nop_2cyc: got st=%0d addr=%h expected 0 %h", state_dbg, mem_addr, PCR + 4); end
   endtask

   task automatic test_alu();
      logic [31:0] prog [17];
      logic [31:0] exp [17];
      prog[0]  = enc_i(8, 0, 8, 5);            exp[0]  = 32'h5;
      prog[1]  = enc_r(8, 8, 9, 0, 32);        exp[1]  = 32'hA;
      prog[2]  = enc_r(8, 9, 10, 0, 34);       exp[2]  = 32'hFFFF_FFFB;
      prog[3]  = enc_r(8, 9, 11, 0, 37);       exp[3]  = 32'hF;
      prog[4]  = enc_r(8, 9, 12, 0, 39);       exp[4]  = 32'hFFFF_FFF0;
      prog[5]  = enc_r(10, 8, 13, 0, 42);      exp[5]  = 32'h1;
      prog[6]  = enc_r(0, 9, 14, 4, 0);        exp[6]  = 32'hA0;
      prog[7]  = enc_r(0, 12, 15, 28, 2);      exp[7]  = 32'hF;
      prog[8]  = enc_i(12, 12, 16, 'hFF0F);    exp[8]  = 32'hFF00;
      prog[9]  = enc_i(13, 0, 17, 'h8001);     exp[9]  = 32'h8001;
      prog[10] = enc_i(8, 0, 18, -1);          exp[10] = 32'hFFFF_FFFF;
      prog[11] = enc_i(15, 0, 19, 'h1234);     exp[11] = 32'h1234_0000;
      prog[12] = enc_i(8, 0, 0, 7);            exp[12] = 32'h7;
      prog[13] = enc_r(0, 0, 20, 0, 32);       exp[13] = 32'h0;
      prog[14] = enc_r(18, 17, 21, 0, 32);     exp[14] = 32'h8000;
      prog[15] = enc_r(9, 10, 22, 0, 36);      exp[15] = 32'hA;
      prog[16] = enc_r(8, 10, 23, 0, 42);      exp[16] = 32'h0;
      clr_imem();
      for (int i = 0; i < 17; i++) imem[i] = prog[i];
      iwait = 0; dwait = 0;
      start();
      for (int k = 0; k < 17; k++) begin
         tick(4);
         checks++; if (ALUResultOut !== exp[k]) begin errors++; $display("FAIL alu_%0d: got %h expected %h", k, ALUResultOut, exp[k]); end
         if (k == 1) begin
            checks++; if (state_dbg !== 4'd0 || mem_addr !== PCR + 8) begin errors++; $display("FAIL alu_8cyc: got st=%0d addr=%h expected 0 %h", state_dbg, mem_addr, PCR + 8); end
         end
      end
   endtask

   task automatic test_mem_wait();
      int w0, b0;
      clr_imem();
      imem[0] = enc_i(8, 0, 9, 10);
      imem[1] = enc_i(43, 0, 9, 0);
      imem[2] = enc_i(35, 0, 10, 0);
      imem[3] = enc_r(10, 0, 11, 0, 32);
      iwait = 0; dwait = 2;
      start();
      w0 = we_cyc; b0 = both_cyc;
      tick(8);
      checks++; if (state_dbg !== 4'd7 || mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hA) begin errors++; $display("FAIL sw_hold: got st=%0d we=%b addr=%h wd=%h expected 7 1 0 a", state_dbg, mem_we, mem_addr, mem_wdata); end
      tick(2);
      checks++; if (state_dbg !== 4'd0 || mem_addr !== PCR + 8) begin errors++; $display("FAIL sw_done: got st=%0d addr=%h expected 0 %h", state_dbg, mem_addr, PCR + 8); end
      checks++; if (we_cyc - w0 !== 3) begin errors++; $display("FAIL we_cycles: got %0d expected 3", we_cyc - w0); end
      checks++; if (dmem[0] !== 32'hA) begin errors++; $display("FAIL sw_data: got %h expected a", dmem[0]); end
      tick(4);
      checks++; if (state_dbg !== 4'd5 || mem_re !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL lw_hold: got st=%0d re=%b addr=%h expected 5 1 0", state_dbg, mem_re, mem_addr); end
      tick(2);
      checks++; if (state_dbg !== 4'd6) begin errors++; $display("FAIL lw_wb: got %0d expected 6", state_dbg); end
      tick(1);
      checks++; if (state_dbg !== 4'd0 || mem_addr !== PCR + 12) begin errors++; $display("FAIL lw_7cyc: got st=%0d addr=%h expected 0 %h", state_dbg, mem_addr, PCR + 12); end
      tick(4);
      checks++; if (ALUResultOut !== 32'hA) begin errors++; $display("FAIL lw_value: got %h expected a", ALUResultOut); end
      checks++; if (both_cyc - b0 !== 0) begin errors++; $display("FAIL re_we_overlap: got %0d expected 0", both_cyc - b0); end
   endtask

   task automatic test_branch();
      clr_imem();
      imem[0] = enc_i(8, 0, 8, 1);
      imem[1] = enc_i(5, 8, 0, 1);     // bne taken, skips imem[2]
      imem[2] = enc_i(8, 0, 9, 2);
      imem[3] = enc_i(5, 0, 0, 5);     // bne not taken
      imem[5] = enc_i(4, 0, 0, -1);    // beq to itself
      iwait = 0; dwait = 0;
      start();
      tick(4);
      checks++; if (mem_addr !== PCR + 4) begin errors++; $display("FAIL br_start: got %h expected %h", mem_addr, PCR + 4); end
      tick(3);
      checks++; if (state_dbg !== 4'd0 || mem_addr !== PCR + 12) begin errors++; $display("FAIL bne_taken: got st=%0d addr=%h expected 0 %h", state_dbg, mem_addr, PCR + 12); end
      tick(3);
      checks++; if (mem_addr !== PCR + 16) begin errors++; $display("FAIL bne_not_taken: got %h expected %h", mem_addr, PCR + 16); end
      tick(2);
      checks++; if (mem_addr !== PCR + 20) begin errors++; $display("FAIL unsupported_nop: got %h expected %h", mem_addr, PCR + 20); end
      tick(2);
      checks++; if (state_dbg !== 4'd9) begin errors++; $display("FAIL beq_state: got %0d expected 9", state_dbg); end
      tick(1);
      checks++; if (state_dbg !== 4'd0 || mem_addr !== PCR + 20) begin errors++; $display("FAIL beq_loop1: got st=%0d addr=%h expected 0 %h", state_dbg, mem_addr, PCR + 20); end
      tick(3);
      checks++; if (mem_addr !== PCR + 20) begin errors++; $display("FAIL beq_loop2: got %h expected %h", mem_addr, PCR + 20); end
   endtask

   task automatic test_io();
      int i0;
      clr_imem();
      imem[0] = enc_i(15, 0, 1, 'h1001);
      imem[1] = enc_i(35, 1, 2, 'h24);
      imem[2] = enc_i(43, 1, 2, 'h24);
      PortIn = 8'hA5;
      iwait = 0; dwait = 2;
      start();
      i0 = io_cyc;
      tick(7);
      checks++; if (state_dbg !== 4'd5 || mem_re !== 1'b0) begin errors++; $display("FAIL io_rd: got st=%0d re=%b expected 5 0", state_dbg, mem_re); end
      tick(1);
      checks++; if (state_dbg !== 4'd6) begin errors++; $display("FAIL io_rd_1cyc: got %0d expected 6", state_dbg); end
      tick(4);
      checks++; if (state_dbg !== 4'd7 || mem_we !== 1'b0) begin errors++; $display("FAIL io_wr: got st=%0d we=%b expected 7 0", state_dbg, mem_we); end
      tick(1);
      checks++; if (PortOut !== 32'h0000_00A5 || mem_addr !== PCR + 12) begin errors++; $display("FAIL io_portout: got port=%h addr=%h expected a5 %h", PortOut, mem_addr, PCR + 12); end
      checks++; if (io_cyc - i0 !== 0) begin errors++; $display("FAIL io_no_bus: got %0d expected 0", io_cyc - i0); end
   endtask

   task automatic test_jump();
      clr_imem();
      imem[0]  = enc_i(8, 0, 8, 3);
      imem[4]  = enc_j(3, 32'h0040_0100);
      imem[5]  = enc_i(8, 8, 10, 1);
      imem[64] = enc_r(31, 0, 9, 0, 32);
      imem[65] = enc_r(31, 0, 0, 0, 8);
      iwait = 0; dwait = 0;
      start();
      tick(10);
      checks++; if (mem_addr !== 32'h0040_0010) begin errors++; $display("FAIL jal_fetch: got %h expected 00400010", mem_addr); end
      tick(3);
      checks++; if (state_dbg !== 4'd0 || mem_addr !== 32'h0040_0100) begin errors++; $display("FAIL jal_target: got st=%0d addr=%h expected 0 00400100", state_dbg, mem_addr); end
      tick(4);
      checks++; if (ALUResultOut !== 32'h0040_0014) begin errors++; $display("FAIL jal_link: got %h expected 00400014", ALUResultOut); end
      tick(3);
      checks++; if (mem_addr !== 32'h0040_0014) begin errors++; $display("FAIL jr_return: got %h expected 00400014", mem_addr); end
      tick(4);
      checks++; if (ALUResultOut !== 32'h4) begin errors++; $display("FAIL after_jr: got %h expected 4", ALUResultOut); end
   endtask

   task automatic test_reset_mid();
      clr_imem();
      imem[0] = enc_i(8, 0, 8, 9);
      imem[1] = enc_i(35, 0, 9, 0);
      iwait = 0; dwait = 5;
      start();
      tick(8);
      checks++; if (state_dbg !== 4'd5 || mem_re !== 1'b1) begin errors++; $display("FAIL mid_wait: got st=%0d re=%b expected 5 1", state_dbg, mem_re); end
      #2 reset = 1'b0;
      #1;
      checks++; if (mem_re !== 1'b0 || state_dbg !== 4'd0) begin errors++; $display("FAIL mid_abort: got re=%b st=%0d expected 0 0", mem_re, state_dbg); end
      checks++; if (ALUResultOut !== 32'h0) begin errors++; $display("FAIL mid_aluout: got %h expected 0", ALUResultOut); end
      clr_imem();
      imem[0] = enc_r(8, 0, 10, 0, 32);
      tick(1);
      reset = 1'b1;
      #1;
      checks++; if (mem_re !== 1'b1 || mem_addr !== PCR) begin errors++; $display("FAIL mid_refetch: got re=%b addr=%h expected 1 %h", mem_re, mem_addr, PCR); end
      tick(4);
      checks++; if (ALUResultOut !== 32'h0 || mem_addr !== PCR + 4) begin errors++; $display("FAIL mid_regs_clear: got alu=%h addr=%h expected 0 %h", ALUResultOut, mem_addr, PCR + 4); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem_wait();
      test_branch();
      test_io();
      test_jump();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mips_multicycle_processor.md
MIPS_MULTICYCLE_PROCESSOR -- requirements
Module: mips_multicycle_processor

Interface
REQ-001 Parameter MEMORY_DEPTH, default 512: words of shared instruction/data space, byte-addressed.
REQ-002 Parameter DATA_WIDTH, default 32: datapath width; instruction width fixed at 32.
REQ-003 Parameter PC_RESET, default 32'h0040_0000: PC value after reset.
REQ-004 Parameter IO_ADDR, default 32'h1001_0024: memory-mapped port address.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 mem_rdata  in  32  read data from unified memory.
REQ-008 mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
REQ-009 PortIn  in  8  input port, read at IO_ADDR, zero-extended.
REQ-010 mem_addr  out  32  byte address (PC or ALU result).
REQ-011 mem_wdata  out  DATA_WIDTH  store data (rt).
REQ-012 mem_re  out  1  read request; held until mem_ready.
REQ-013 mem_we  out  1  write request; held until mem_ready.
REQ-014 PortOut  out  DATA_WIDTH  registered output port, written by sw to IO_ADDR.
REQ-015 ALUResultOut  out  DATA_WIDTH  registered ALUOut.
REQ-016 state_dbg  out  4  current controller state encoding.

Function
REQ-017 Controller SHALL be an FSM: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP.
REQ-018 FETCH: mem_re=1, mem_addr=PC; on mem_ready, IR<=mem_rdata, PC<=PC+4, go DECODE; else stay FETCH with IR/PC unchanged.
REQ-019 DECODE: A<=rs, B<=rt, ALUOut<=PC+(signext(imm)<<2); next state by opcode.
REQ-020 Supported: add, sub, and, or, nor, slt, sll, srl, jr, addi, andi, ori, lui, lw, sw, beq, bne, j, jal; any other opcode SHALL return to FETCH with no state change (NOP).
REQ-021 Cycle counts with zero-wait memory: R/I-ALU 4, lw 5, sw 4, beq/bne/j/jal/jr 3; each memory wait cycle adds 1.
REQ-022 EXEC_R/EXEC_I -> ALU_WB: rd (R) or rt (I) <= ALUOut; andi/ori zero-extend, addi sign-extends, lui writes imm<<16.
REQ-023 BRANCH: beq taken if A==B, bne if A!=B; taken PC<=ALUOut from DECODE.
REQ-024 JUMP: j/jal PC<={PC[31:28],target,2'b00}; jal writes $31<=PC(+4 already applied); jr PC<=A.
REQ-025 MEM_RD/MEM_WR hold mem_re/mem_we and address stable until mem_ready; MDR captured on mem_ready.
REQ-026 Access to IO_ADDR SHALL bypass the memory handshake: lw returns {zeros,PortIn} in one cycle, sw updates PortOut in one cycle; mem_re/mem_we remain 0.
REQ-027 Writes to register $0 SHALL be discarded; $0 reads 0.
REQ-028 mem_re and mem_we SHALL never be 1 in the same cycle.
REQ-029 Arithmetic wraps modulo 2^DATA_WIDTH; no overflow exception.
REQ-030 mem_ready asserted outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-031 While reset=0: state=FETCH, PC=PC_RESET, IR/A/B/ALUOut/MDR/PortOut/ALUResultOut=0, registers=0, mem_re=mem_we=0.
REQ-032 Reset asserted mid-access SHALL abort it; first cycle after release is FETCH at PC_RESET.

Structure
REQ-033 Opcode/funct constants, state encoding and ALU operation codes SHALL reside in shared package mips_pkg.
REQ-034 FSM SHALL be sub-module mips_mc_control; the existing RegisterFile and ALU blocks are reused.

Verification
REQ-035 addi $t0,$0,5; add $t1,$t0,$t0, zero-wait -> $t1=10 after 8 cycles, ALUResultOut=10.
REQ-036 sw $t1,0 then lw $t2,0 with mem_ready delayed 2 cycles per access -> mem_we held 3 cycles, $t2=10, lw takes 7 cycles.
REQ-037 beq $0,$0,-1 -> PC returns to same address every 3 cycles; bne $0,$0 -> PC+4.
REQ-038 PortIn=8'hA5, lw from IO_ADDR then sw to IO_ADDR -> PortOut=32'h0000_00A5, mem_re/mem_we never asserted.
REQ-039 jal at 0x0040_0010 to 0x0040_0100 -> $31=0x0040_0014; jr $31 returns there.
REQ-040 reset pulsed during MEM_RD wait -> mem_re drops immediately; next FETCH at PC_RESET, registers 0.
